id_decode_stage: RTL

- Registered RV32I decode stage for the miniRV core. It is the producing end of the ALU control interface.
- Takes a fetched instruction and PC through a valid/ready handshake.
- Decodes them into the 6-bit ALU op code, operand selects, immediate, register indices and memory/branch controls.
- Presents the result to the EX stage from one pipeline register, with backpressure, flush and a decoded-instruction counter.

---
 rtl/id_decode_stage.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_decode_stage.sv
// Registered RV32I decode stage, producing end of the miniRV ALU control interface.
// Optional build macro ID_DECODE_ILLEGAL_EN adds the registered illegal_o flag.
module id_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [5:0]       alu_op_o,
    output logic [1:0]       a_sel_o,
    output logic             b_sel_o,
    output logic [31:0]      imm_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic             reg_we_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic [2:0]       mem_size_o,
    output logic [2:0]       br_type_o,
    output logic [CNT_W-1:0] dec_cnt_o
`ifdef ID_DECODE_ILLEGAL_EN
    ,
    output logic             illegal_o
`endif
);

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    localparam logic [5:0] ALU_ADD  = 6'h10;
    localparam logic [5:0] ALU_SUB  = 6'h30;
    localparam logic [5:0] ALU_SLT  = 6'h28;
    localparam logic [5:0] ALU_SLTU = 6'h20;
    localparam logic [5:0] ALU_AND  = 6'h01;
    localparam logic [5:0] ALU_OR   = 6'h02;
    localparam logic [5:0] ALU_XOR  = 6'h03;
    localparam logic [5:0] ALU_SLL  = 6'h14;
    localparam logic [5:0] ALU_SRL  = 6'h04;
    localparam logic [5:0] ALU_SRA  = 6'h0C;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic [2:0]  br_type;
    } dec_t;

    function automatic logic [5:0] alu_base(input logic [2:0] f3);
        logic [5:0] op;
        case (f3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SRL;
            3'd6:    op = ALU_OR;
            3'd7:    op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;
    logic        w_legal;
    logic        w_ready;
    dec_t        w_dec;
    dec_t        w_bundle;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    dec_t            r_bundle;
    logic [CNT_W-1:0] r_cnt;

    assign w_opc    = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u  = {instr_i[31:12], 12'h000};
    assign w_imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign w_imm_sh = {27'd0, instr_i[24:20]};
    assign w_ready  = !r_valid || ready_i;

    // Field decode; unused register indices stay zero so rd=0 also gates writeback.
    always_comb begin
        w_dec        = '0;
        w_dec.alu_op = ALU_ADD;
        w_legal      = 1'b0;
        if (instr_i[1:0] == 2'b11) begin
            case (w_opc)
                OPC_LUI: begin
                    w_legal = 1'b1; w_dec.a_sel = 2'd2; w_dec.b_sel = 1'b1;
                    w_dec.imm = w_imm_u; w_dec.rd = instr_i[11:7];
                end
                OPC_AUIPC: begin
                    w_legal = 1'b1; w_dec.a_sel = 2'd1; w_dec.b_sel = 1'b1;
                    w_dec.imm = w_imm_u; w_dec.rd = instr_i[11:7];
                end
                OPC_JAL: begin
                    w_legal = 1'b1; w_dec.a_sel = 2'd1; w_dec.b_sel = 1'b1;
                    w_dec.imm = w_imm_j; w_dec.rd = instr_i[11:7]; w_dec.br_type = 3'd7;
                end
                OPC_JALR: begin
                    w_legal = (w_f3 == 3'd0); w_dec.b_sel = 1'b1; w_dec.imm = w_imm_i;
                    w_dec.rs1 = instr_i[19:15]; w_dec.rd = instr_i[11:7]; w_dec.br_type = 3'd7;
                end
                OPC_BR: begin
                    w_legal = 1'b1; w_dec.imm = w_imm_b;
                    w_dec.rs1 = instr_i[19:15]; w_dec.rs2 = instr_i[24:20];
                    case (w_f3)
                        3'd0:    begin w_dec.br_type = 3'd1; w_dec.alu_op = ALU_SUB;  end
                        3'd1:    begin w_dec.br_type = 3'd2; w_dec.alu_op = ALU_SUB;  end
                        3'd4:    begin w_dec.br_type = 3'd3; w_dec.alu_op = ALU_SLT;  end
                        3'd5:    begin w_dec.br_type = 3'd4; w_dec.alu_op = ALU_SLT;  end
                        3'd6:    begin w_dec.br_type = 3'd5; w_dec.alu_op = ALU_SLTU; end
                        3'd7:    begin w_dec.br_type = 3'd6; w_dec.alu_op = ALU_SLTU; end
                        default: w_legal = 1'b0;
                    endcase
                end
                OPC_LOAD: begin
                    w_legal = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
                    w_dec.b_sel = 1'b1; w_dec.imm = w_imm_i; w_dec.rs1 = instr_i[19:15];
                    w_dec.rd = instr_i[11:7]; w_dec.mem_re = 1'b1; w_dec.mem_size = w_f3;
                end
                OPC_STORE: begin
                    w_legal = (w_f3 <= 3'd2); w_dec.b_sel = 1'b1; w_dec.imm = w_imm_s;
                    w_dec.rs1 = instr_i[19:15]; w_dec.rs2 = instr_i[24:20];
                    w_dec.mem_we = 1'b1; w_dec.mem_size = w_f3;
                end
                OPC_OPIMM: begin
                    w_dec.b_sel = 1'b1; w_dec.rs1 = instr_i[19:15]; w_dec.rd = instr_i[11:7];
                    case (w_f3)
                        3'd1: begin
                            w_legal = (w_f7 == 7'h00); w_dec.alu_op = ALU_SLL; w_dec.imm = w_imm_sh;
                        end
                        3'd5: begin
                            w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                            w_dec.alu_op = (w_f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                            w_dec.imm = w_imm_sh;
                        end
                        default: begin
                            w_legal = 1'b1; w_dec.alu_op = alu_base(w_f3); w_dec.imm = w_imm_i;
                        end
                    endcase
                end
                OPC_OP: begin
                    w_dec.rs1 = instr_i[19:15]; w_dec.rs2 = instr_i[24:20]; w_dec.rd = instr_i[11:7];
                    case (w_f7)
                        7'h00: begin w_legal = 1'b1; w_dec.alu_op = alu_base(w_f3); end
                        7'h20: begin
                            w_legal = (w_f3 == 3'd0) || (w_f3 == 3'd5);
                            w_dec.alu_op = (w_f3 == 3'd5) ? ALU_SRA : ALU_SUB;
                        end
                        default: w_legal = 1'b0;
                    endcase
                end
                default: w_legal = 1'b0;
            endcase
        end else begin
            w_legal = 1'b0;
        end
        w_dec.reg_we = (w_dec.rd != 5'd0);
    end

    // Anything not recognised collapses to the NOP bundle.
    always_comb begin
        w_bundle = w_dec;
        if (w_legal) begin
            w_bundle = w_dec;
        end else begin
            w_bundle        = '0;
            w_bundle.alu_op = ALU_ADD;
        end
    end

    // Pipeline register: flush beats load, load beats drain, otherwise hold.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_bundle <= '0;
        end else if (flush_i) begin
            r_valid  <= 1'b0;
        end else if (valid_i && w_ready) begin
            r_valid  <= 1'b1;
            r_pc     <= pc_i;
            r_bundle <= w_bundle;
        end else if (r_valid && ready_i) begin
            r_valid  <= 1'b0;
        end
    end

    // Counts every bundle EX takes, including one leaving in a flush cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (r_valid && ready_i) begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
        end
    end

`ifdef ID_DECODE_ILLEGAL_EN
    logic r_illegal;

    // Illegal flag travels with the bundle and is cleared by flush.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            r_illegal <= 1'b0;
        end else if (valid_i && w_ready) begin
            r_illegal <= !w_legal;
        end
    end

    assign illegal_o = r_illegal;
`endif

    assign ready_o    = w_ready;
    assign valid_o    = r_valid;
    assign pc_o       = r_pc;
    assign alu_op_o   = r_bundle.alu_op;
    assign a_sel_o    = r_bundle.a_sel;
    assign b_sel_o    = r_bundle.b_sel;
    assign imm_o      = r_bundle.imm;
    assign rs1_o      = r_bundle.rs1;
    assign rs2_o      = r_bundle.rs2;
    assign rd_o       = r_bundle.rd;
    assign reg_we_o   = r_bundle.reg_we;
    assign mem_re_o   = r_bundle.mem_re;
    assign mem_we_o   = r_bundle.mem_we;
    assign mem_size_o = r_bundle.mem_size;
    assign br_type_o  = r_bundle.br_type;
    assign dec_cnt_o  = r_cnt;

endmodule
